mcpu_ctrl: RTL and testbench
============================

Name: mcpu_ctrl

Overview:
- Parametrised multi-cycle successor to the single-cycle SCPU control unit.
- Decodes the RV32I subset from the stored instruction fields (OPcode = inst[6:2], Fun3, Fun7 = inst[30]) and sequences fetch, decode, execute, memory and write-back over several cycles.
- Stalls on MIO_ready for every memory access, with an optional bounded-wait timeout, and traps on illegal opcodes.
- Sits between the instruction register and the multi-cycle datapath muxes inside the CPU core.

Parameters:
TIMEOUT_CYCLES, 16, max cycles waiting on MIO_ready per access; 0 disables the timeout
TIMEOUT_W, 5, counter width, must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES
TRAP_EN, 1, 1 = illegal opcode enters TRAP; 0 = treated as NOP (return to IF)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
OPcode  input  5  inst[6:2] from the instruction register
Fun3  input  3  inst[14:12]
Fun7  input  1  inst[30]
MIO_ready  input  1  memory access completes this cycle
MemRead  output  1  memory read request
MemRW  output  1  memory write request
IorD  output  1  0 = PC address, 1 = ALUOut address
IRWrite  output  1  load instruction register
PCWrite  output  1  unconditional PC update
Branch  output  1  conditional PC update (beq: PC written if zero)
RegWrite  output  1  register file write
MemtoReg  output  2  00 ALUOut, 01 MDR, 10 PC+4, 11 imm
ALUSrc_A  output  2  00 PC, 01 rs1, 10 oldPC
ALUSrc_B  output  2  00 rs2, 01 const 4, 10 imm
ALUop  output  2  00 add, 01 sub (branch), 10 R-type, 11 I-type
ALU_Control  output  3  final ALU operation
PCSource  output  2  00 ALU result, 01 ALUOut, 10 ALU result & ~1
illegal  output  1  one-cycle pulse on illegal opcode
timeout  output  1  one-cycle pulse when the wait limit expires
state  output  4  current state code, for debug

Behaviour:
- State register, wait counter and pulse flags: flip-flops, async clear on rst_n low. Reset state is IF (code 0).
- Outputs are combinational from state, plus MIO_ready where noted.
- While rst_n is low, every output is 0 and state reads 0.
- States and codes: IF 0, ID 1, MA 2, MRD 3, MWB 4, MWR 5, EXR 6, EXI 7, AWB 8, BR 9, JAL 10, JALR 11, LUI 12, TRAP 15.
- IF: MemRead=1, IorD=0, ALUSrc_A=00, ALUSrc_B=01, ALUop=00.
  - IRWrite=PCWrite=MIO_ready.
  - Moves to ID only when MIO_ready=1.
- ID: ALUSrc_A=10, ALUSrc_B=10, ALUop=00 (branch target into ALUOut). Dispatch on OPcode:
  - 00000 or 01000 -> MA
  - 01100 -> EXR
  - 00100 -> EXI
  - 11000 -> BR
  - 11011 -> JAL
  - 11001 -> JALR
  - 01101 -> LUI
  - any other opcode -> TRAP if TRAP_EN, else IF. illegal pulses for one cycle in either case.
- MA: ALUSrc_A=01, ALUSrc_B=10, ALUop=00. Goes to MRD (load) or MWR (store).
- MRD: MemRead=1, IorD=1. Goes to MWB on MIO_ready.
- MWB: RegWrite=1, MemtoReg=01. Goes to IF.
- MWR: MemRW=1, IorD=1. Goes to IF on MIO_ready.
- EXR: ALUSrc_A=01, ALUSrc_B=00, ALUop=10. Goes to AWB.
- EXI: as EXR but ALUSrc_B=10, ALUop=11. Goes to AWB.
- AWB: RegWrite=1, MemtoReg=00. Goes to IF.
- BR: ALUSrc_A=01, ALUSrc_B=00, ALUop=01, Branch=1, PCSource=01. Goes to IF.
- JAL: PCWrite=1, PCSource=01, RegWrite=1, MemtoReg=10. Goes to IF.
- JALR: ALUSrc_A=01, ALUSrc_B=10, ALUop=00, PCWrite=1, PCSource=10, RegWrite=1, MemtoReg=10. Goes to IF.
- LUI: RegWrite=1, MemtoReg=11. Goes to IF.
- TRAP: all enables 0. Held until reset.
- ALU_Control is held during stalls.
  - ALUop 00 -> 010; ALUop 01 -> 110.
  - ALUop 10 (R-type), by {Fun3,Fun7}: 000/0 -> 010 add, 000/1 -> 110 sub, 111 -> 000 and, 110 -> 001 or, 010 -> 111 slt, 101 -> 101 srl, 100 -> 011 xor, 001 -> 100 sll, other -> 010.
  - ALUop 11 (I-type): same map but Fun7 ignored, so Fun3=000 is always add.
- Wait counter:
  - Clears on entry to IF, MRD or MWR; increments each cycle those states see MIO_ready=0.
  - If TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES: timeout pulses for one cycle, the access is abandoned, and the next state is TRAP if TRAP_EN, else IF. No write enables are asserted that cycle.
- MIO_ready rising on the same cycle the limit is reached: the access completes normally and timeout stays 0.
- Reset asserted mid-instruction: immediate return to IF with outputs 0; no partial write-back afterwards.

Test Plan:
- Reset, then hold MIO_ready=0 for 3 cycles in IF, then 1 -> state stays 0 for 3 cycles, with IRWrite=PCWrite=1 only in the ready cycle; state=1 next cycle.
- R-type walk: OPcode=01100 with {Fun3,Fun7} of 000/0, 000/1, 111/0, 110/0, 010/0, 101/0, 100/0 -> in EXR, ALU_Control = 010, 110, 000, 001, 111, 101, 011; AWB has RegWrite=1, MemtoReg=00.
- Load with MIO_ready=1 -> state sequence 0,1,2,3,4,0; MWB has RegWrite=1, MemtoReg=01. Store -> sequence 0,1,2,5,0; MemRW=1 and IorD=1 in state 5.
- Branches and jumps:
  - OPcode=11000 -> BR: ALUop=01, Branch=1, ALU_Control=110.
  - OPcode=11011 -> JAL: PCWrite=1, RegWrite=1, MemtoReg=10.
  - OPcode=00100, Fun3=000, Fun7=1 -> ALU_Control=010.
- OPcode=5'h1f with TRAP_EN=1 -> illegal pulses once, state=15 and stays there.
- MIO_ready held 0 in MRD with TIMEOUT_CYCLES=4 -> timeout pulses once and state=15, RegWrite never asserted. Assert rst_n=0 mid-EXR -> all outputs 0 immediately, state=0.

Source files
------------

// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl: multi-cycle control FSM for an RV32I subset. Sequences IF/ID/EX/MEM/WB,
// stalls on MIO_ready with an optional bounded wait, and traps illegal opcodes.
module mcpu_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_W      = 5,
  parameter bit TRAP_EN        = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] OPcode,
  input  logic [2:0] Fun3,
  input  logic       Fun7,
  input  logic       MIO_ready,
  output logic       MemRead,
  output logic       MemRW,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       RegWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrc_A,
  output logic [1:0] ALUSrc_B,
  output logic [1:0] ALUop,
  output logic [2:0] ALU_Control,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic       timeout,
  output logic [3:0] state
);

  localparam logic [3:0] S_IF  = 4'd0,  S_ID  = 4'd1,  S_MA   = 4'd2,  S_MRD = 4'd3;
  localparam logic [3:0] S_MWB = 4'd4,  S_MWR = 4'd5,  S_EXR  = 4'd6,  S_EXI = 4'd7;
  localparam logic [3:0] S_AWB = 4'd8,  S_BR  = 4'd9,  S_JAL  = 4'd10, S_JALR = 4'd11;
  localparam logic [3:0] S_LUI = 4'd12, S_TRAP = 4'd15;

  localparam logic [4:0] OP_LOAD = 5'b00000, OP_STORE = 5'b01000, OP_RTYPE = 5'b01100;
  localparam logic [4:0] OP_ITYPE = 5'b00100, OP_BRANCH = 5'b11000, OP_JAL = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001, OP_LUI = 5'b01101;

  localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam bit                   TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [3:0]           ABORT_ST = TRAP_EN ? S_TRAP : S_IF;

  logic [3:0]           state_reg, state_next;
  logic [TIMEOUT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic                 illegal_reg, illegal_next;
  logic                 timeout_reg, timeout_next;
  logic                 waiting, expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IF;
      wait_cnt_reg <= '0;
      illegal_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      illegal_reg  <= illegal_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    waiting      = (state_reg == S_IF) || (state_reg == S_MRD) || (state_reg == S_MWR);
    // A ready arriving on the limit cycle still completes the access.
    expire       = TO_EN && waiting && !MIO_ready && (wait_cnt_reg == TO_LIMIT);
    state_next   = state_reg;
    illegal_next = 1'b0;
    timeout_next = expire;
    case (state_reg)
      S_IF:  if (expire) state_next = ABORT_ST; else if (MIO_ready) state_next = S_ID;
      S_ID: begin
        case (OPcode)
          OP_LOAD, OP_STORE: state_next = S_MA;
          OP_RTYPE:          state_next = S_EXR;
          OP_ITYPE:          state_next = S_EXI;
          OP_BRANCH:         state_next = S_BR;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          default: begin
            state_next   = ABORT_ST;
            illegal_next = 1'b1;
          end
        endcase
      end
      S_MA:  state_next = (OPcode == OP_STORE) ? S_MWR : S_MRD;
      S_MRD: if (expire) state_next = ABORT_ST; else if (MIO_ready) state_next = S_MWB;
      S_MWR: if (expire) state_next = ABORT_ST; else if (MIO_ready) state_next = S_IF;
      S_EXR, S_EXI: state_next = S_AWB;
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_IF;
    endcase
    // Counter restarts on every state change (and on an abandoned access), saturating otherwise.
    if ((state_next != state_reg) || expire)
      wait_cnt_next = '0;
    else if (waiting && !MIO_ready && !(&wait_cnt_reg))
      wait_cnt_next = wait_cnt_reg + 1'b1;
    else
      wait_cnt_next = wait_cnt_reg;
  end

  always_comb begin
    MemRead = 1'b0; MemRW = 1'b0; IorD = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0;
    Branch = 1'b0; RegWrite = 1'b0; MemtoReg = 2'b00; ALUSrc_A = 2'b00;
    ALUSrc_B = 2'b00; ALUop = 2'b00; ALU_Control = 3'b000; PCSource = 2'b00;
    if (rst_n) begin
      case (state_reg)
        S_IF: begin
          MemRead = 1'b1; ALUSrc_B = 2'b01;
          IRWrite = MIO_ready; PCWrite = MIO_ready;
        end
        S_ID:  begin ALUSrc_A = 2'b10; ALUSrc_B = 2'b10; end
        S_MA:  begin ALUSrc_A = 2'b01; ALUSrc_B = 2'b10; end
        S_MRD: begin MemRead = 1'b1; IorD = 1'b1; end
        S_MWB: begin RegWrite = 1'b1; MemtoReg = 2'b01; end
        S_MWR: begin MemRW = 1'b1; IorD = 1'b1; end
        S_EXR: begin ALUSrc_A = 2'b01; ALUop = 2'b10; end
        S_EXI: begin ALUSrc_A = 2'b01; ALUSrc_B = 2'b10; ALUop = 2'b11; end
        S_AWB: RegWrite = 1'b1;
        S_BR:  begin ALUSrc_A = 2'b01; ALUop = 2'b01; Branch = 1'b1; PCSource = 2'b01; end
        S_JAL: begin PCWrite = 1'b1; PCSource = 2'b01; RegWrite = 1'b1; MemtoReg = 2'b10; end
        S_JALR: begin
          ALUSrc_A = 2'b01; ALUSrc_B = 2'b10; PCWrite = 1'b1; PCSource = 2'b10;
          RegWrite = 1'b1; MemtoReg = 2'b10;
        end
        S_LUI: begin RegWrite = 1'b1; MemtoReg = 2'b11; end
        default: ;
      endcase
      case (ALUop)
        2'b00: ALU_Control = 3'b010;
        2'b01: ALU_Control = 3'b110;
        default: begin
          case (Fun3)
            3'b000:  ALU_Control = ((ALUop == 2'b10) && Fun7) ? 3'b110 : 3'b010;
            3'b111:  ALU_Control = 3'b000;
            3'b110:  ALU_Control = 3'b001;
            3'b010:  ALU_Control = 3'b111;
            3'b101:  ALU_Control = 3'b101;
            3'b100:  ALU_Control = 3'b011;
            3'b001:  ALU_Control = 3'b100;
            default: ALU_Control = 3'b010;
          endcase
        end
      endcase
    end
  end

  assign state   = state_reg;
  assign illegal = illegal_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb_mcpu_ctrl: instruction-level reference model pushes expected per-cycle control
// vectors into a scoreboard queue; a negedge monitor pops and compares them.
module tb_mcpu_ctrl;

  localparam int TO = 4;
  localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_MA = 4'd2, S_MRD = 4'd3, S_MWB = 4'd4;
  localparam logic [3:0] S_MWR = 4'd5, S_EXR = 4'd6, S_EXI = 4'd7, S_AWB = 4'd8, S_BR = 4'd9;
  localparam logic [3:0] S_JAL = 4'd10, S_JALR = 4'd11, S_LUI = 4'd12, S_TRAP = 4'd15;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_read, mem_rw, iord, ir_write, pc_write, branch, reg_write;
    logic [1:0] mem_to_reg, src_a, src_b, alu_op;
    logic [2:0] alu_ctl;
    logic [1:0] pc_src;
    logic       illegal, timeout;
  } ctl_t;

  typedef struct {
    ctl_t  v;
    string name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] opcode = '0;
  logic [2:0] fun3 = '0;
  logic       fun7 = 1'b0;
  logic       mio_ready = 1'b0;
  logic       mem_read, mem_rw, iord, ir_write, pc_write, branch, reg_write;
  logic [1:0] mem_to_reg, src_a, src_b, alu_op, pc_src;
  logic [2:0] alu_ctl;
  logic       illegal, timeout;
  logic [3:0] state;

  exp_t exp_q[$];
  exp_t cur;
  ctl_t act;
  int   checks = 0;
  int   errors = 0;
  bit   pend_ill = 1'b0;
  bit   pend_to = 1'b0;
  int   n_insn = 0;

  always #5 clk = ~clk;

  mcpu_ctrl #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(3), .TRAP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .OPcode(opcode), .Fun3(fun3), .Fun7(fun7),
    .MIO_ready(mio_ready), .MemRead(mem_read), .MemRW(mem_rw), .IorD(iord),
    .IRWrite(ir_write), .PCWrite(pc_write), .Branch(branch), .RegWrite(reg_write),
    .MemtoReg(mem_to_reg), .ALUSrc_A(src_a), .ALUSrc_B(src_b), .ALUop(alu_op),
    .ALU_Control(alu_ctl), .PCSource(pc_src), .illegal(illegal), .timeout(timeout),
    .state(state)
  );

  // Monitor: one comparison per cycle whenever an expectation is queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      act = {state, mem_read, mem_rw, iord, ir_write, pc_write, branch, reg_write,
             mem_to_reg, src_a, src_b, alu_op, alu_ctl, pc_src, illegal, timeout};
      checks++;
      if (act !== cur.v) begin
        errors++;
        $display("FAIL %s @%0t: got %h (state %0d) expected %h (state %0d)",
                 cur.name, $time, act, act.st, cur.v, cur.v.st);
      end
    end
  end

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return f7 ? 3'b110 : 3'b010;
      3'b111:  return 3'b000;
      3'b110:  return 3'b001;
      3'b010:  return 3'b111;
      3'b101:  return 3'b101;
      3'b100:  return 3'b011;
      3'b001:  return 3'b100;
      default: return 3'b010;
    endcase
  endfunction

  function automatic ctl_t ctl_of(input logic [3:0] st, input logic rdy,
                                  input logic [2:0] f3, input logic f7);
    ctl_t c;
    c = '0;
    c.st = st;
    c.alu_ctl = 3'b010;
    case (st)
      S_IF:   begin c.mem_read = 1; c.src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      S_ID:   begin c.src_a = 2'b10; c.src_b = 2'b10; end
      S_MA:   begin c.src_a = 2'b01; c.src_b = 2'b10; end
      S_MRD:  begin c.mem_read = 1; c.iord = 1; end
      S_MWB:  begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
      S_MWR:  begin c.mem_rw = 1; c.iord = 1; end
      S_EXR:  begin c.src_a = 2'b01; c.alu_op = 2'b10; c.alu_ctl = alu_of(f3, f7); end
      S_EXI:  begin c.src_a = 2'b01; c.src_b = 2'b10; c.alu_op = 2'b11; c.alu_ctl = alu_of(f3, 1'b0); end
      S_AWB:  c.reg_write = 1;
      S_BR:   begin c.src_a = 2'b01; c.alu_op = 2'b01; c.branch = 1; c.pc_src = 2'b01; c.alu_ctl = 3'b110; end
      S_JAL:  begin c.pc_write = 1; c.pc_src = 2'b01; c.reg_write = 1; c.mem_to_reg = 2'b10; end
      S_JALR: begin
        c.src_a = 2'b01; c.src_b = 2'b10; c.pc_write = 1; c.pc_src = 2'b10;
        c.reg_write = 1; c.mem_to_reg = 2'b10;
      end
      S_LUI:  begin c.reg_write = 1; c.mem_to_reg = 2'b11; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic cyc(input logic rdy, input ctl_t e, input string nm);
    mio_ready = rdy;
    e.illegal = pend_ill;
    e.timeout = pend_to;
    pend_ill = 1'b0;
    pend_to = 1'b0;
    exp_q.push_back(exp_t'{e, nm});
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    pend_ill = 1'b0;
    pend_to = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mio_ready = rbit();
      exp_q.push_back(exp_t'{ctl_t'('0), "RESET"});
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  // Memory/fetch access: 'stalls' not-ready cycles, abandoned after TO of them.
  task automatic access(input logic [3:0] st, input int stalls, input string nm, output bit ok);
    ok = 1'b1;
    for (int k = 0; k <= stalls; k++) begin
      if (k == stalls) begin
        cyc(1'b1, ctl_of(st, 1'b1, 3'b0, 1'b0), nm);
      end else begin
        cyc(1'b0, ctl_of(st, 1'b0, 3'b0, 1'b0), nm);
        if (k == TO) begin
          pend_to = 1'b1;
          ok = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic run_insn(input logic [4:0] op, input logic [2:0] f3, input logic f7,
                          input int s_if, input int s_mem, input bit rst_ex);
    bit ok;
    string outcome;
    outcome = "retired";
    opcode = op;
    fun3 = f3;
    fun7 = f7;
    access(S_IF, s_if, "IF", ok);
    if (!ok) outcome = "fetch timeout";
    if (ok) begin
      cyc(rbit(), ctl_of(S_ID, 1'b0, f3, f7), "ID");
      case (op)
        5'b00000: begin
          cyc(rbit(), ctl_of(S_MA, 1'b0, f3, f7), "MA");
          access(S_MRD, s_mem, "MRD", ok);
          if (ok) cyc(rbit(), ctl_of(S_MWB, 1'b0, f3, f7), "MWB");
          else outcome = "load timeout";
        end
        5'b01000: begin
          cyc(rbit(), ctl_of(S_MA, 1'b0, f3, f7), "MA");
          access(S_MWR, s_mem, "MWR", ok);
          if (!ok) outcome = "store timeout";
        end
        5'b01100: begin
          if (rst_ex) begin
            do_reset();
            outcome = "reset in EXR";
          end else begin
            cyc(rbit(), ctl_of(S_EXR, 1'b0, f3, f7), "EXR");
            cyc(rbit(), ctl_of(S_AWB, 1'b0, f3, f7), "AWB");
          end
        end
        5'b00100: begin
          cyc(rbit(), ctl_of(S_EXI, 1'b0, f3, f7), "EXI");
          cyc(rbit(), ctl_of(S_AWB, 1'b0, f3, f7), "AWB");
        end
        5'b11000: cyc(rbit(), ctl_of(S_BR, 1'b0, f3, f7), "BR");
        5'b11011: cyc(rbit(), ctl_of(S_JAL, 1'b0, f3, f7), "JAL");
        5'b11001: cyc(rbit(), ctl_of(S_JALR, 1'b0, f3, f7), "JALR");
        5'b01101: cyc(rbit(), ctl_of(S_LUI, 1'b0, f3, f7), "LUI");
        default: begin
          pend_ill = 1'b1;
          ok = 1'b0;
          outcome = "illegal";
        end
      endcase
    end
    if (!ok) begin
      for (int i = 0; i < 3; i++) cyc(rbit(), ctl_of(S_TRAP, 1'b0, f3, f7), "TRAP");
      do_reset();
    end
    n_insn++;
    $display("insn %0d: op=%05b f3=%03b f7=%0b stall_if=%0d stall_mem=%0d -> %s",
             n_insn, op, f3, f7, s_if, s_mem, outcome);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] walk_f3[7];
    logic       walk_f7[7];
    logic [4:0] legal_ops[8];
    logic [4:0] op;
    int         s_if, s_mem;
    walk_f3 = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010, 3'b101, 3'b100};
    walk_f7 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    legal_ops = '{5'b00000, 5'b01000, 5'b01100, 5'b00100, 5'b11000, 5'b11011, 5'b11001, 5'b01101};

    @(posedge clk);
    #1;
    do_reset();

    run_insn(5'b01100, 3'b000, 1'b0, 3, 0, 1'b0);
    for (int i = 0; i < 7; i++) run_insn(5'b01100, walk_f3[i], walk_f7[i], 0, 0, 1'b0);
    run_insn(5'b00000, 3'b010, 1'b0, 0, 0, 1'b0);
    run_insn(5'b01000, 3'b010, 1'b0, 0, 0, 1'b0);
    run_insn(5'b11000, 3'b000, 1'b0, 0, 0, 1'b0);
    run_insn(5'b11011, 3'b000, 1'b0, 0, 0, 1'b0);
    run_insn(5'b00100, 3'b000, 1'b1, 0, 0, 1'b0);
    run_insn(5'b11001, 3'b000, 1'b0, 1, 0, 1'b0);
    run_insn(5'b01101, 3'b000, 1'b0, 0, 0, 1'b0);
    run_insn(5'h1f, 3'b000, 1'b0, 0, 0, 1'b0);
    run_insn(5'b00000, 3'b010, 1'b0, 0, 10, 1'b0);
    run_insn(5'b01000, 3'b010, 1'b0, 0, TO, 1'b0);
    run_insn(5'b01100, 3'b111, 1'b0, 0, 0, 1'b1);
    run_insn(5'b00100, 3'b110, 1'b0, 6, 0, 1'b0);
    run_insn(5'b00000, 3'b010, 1'b0, TO, TO, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) op = 5'($urandom_range(0, 31));
      else op = legal_ops[$urandom_range(0, 7)];
      s_if  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 2));
      s_mem = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 2));
      run_insn(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), s_if, s_mem,
               ($urandom_range(0, 5) == 0));
    end

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
